// File: rtl/ym3438_dac_rx.sv
// Channel-output receiver: decodes the slot-multiplexed offset-binary stream,
// sums left/right over one sample period and latches a stereo PCM sample.
module ym3438_dac_rx #(
   parameter int unsigned SLOTS = 24,
   parameter int unsigned OUT_W = 16
) (
   input  logic             MCLK,
   input  logic             reset_n,
   input  logic             c1,
   input  logic             sync,
   input  logic [8:0]       ch_out,
   input  logic [1:0]       ch_pan,
   input  logic             mute,
   output logic [OUT_W-1:0] out_l,
   output logic [OUT_W-1:0] out_r,
   output logic             sample_valid,
   output logic             locked,
   output logic             sync_err
);

   localparam int unsigned CntW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [CntW-1:0] CntLast  = CntW'(SLOTS - 1);
   localparam logic [CntW-1:0] CntStart = CntW'((SLOTS > 1) ? 1 : 0);
   localparam int unsigned Shift = OUT_W - 14;

   typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   slot_cnt_q, slot_cnt_d;
   logic signed [13:0] acc_l_q, acc_l_d;
   logic signed [13:0] acc_r_q, acc_r_d;
   logic [OUT_W-1:0]  out_l_d, out_r_d;
   logic              valid_d, locked_d, err_d;
   logic signed [8:0] val;
   logic signed [13:0] c_l, c_r;
   logic              cnt_zero, boundary;

   // Flipping the MSB turns offset binary into two's complement.
   assign val      = {~ch_out[8], ch_out[7:0]};
   assign c_l      = (ch_pan[1] & ~mute) ? 14'(val) : '0;
   assign c_r      = (ch_pan[0] & ~mute) ? 14'(val) : '0;
   assign cnt_zero = (slot_cnt_q == '0);
   assign boundary = sync | cnt_zero;

   always_comb begin
      state_d    = state_q;
      slot_cnt_d = slot_cnt_q;
      acc_l_d    = acc_l_q;
      acc_r_d    = acc_r_q;
      out_l_d    = out_l;
      out_r_d    = out_r;
      valid_d    = 1'b0;
      locked_d   = locked;
      err_d      = sync_err;
      if (c1) begin
         case (state_q)
            StUnlocked: begin
               if (sync) begin
                  state_d    = StLocked;
                  locked_d   = 1'b1;
                  acc_l_d    = c_l;
                  acc_r_d    = c_r;
                  slot_cnt_d = CntStart;
               end
            end
            StLocked: begin
               // Early sync or missing sync both flag; the boundary is taken either way.
               if ((sync && !cnt_zero) || (!sync && cnt_zero)) begin
                  err_d = 1'b1;
               end
               if (boundary) begin
                  out_l_d    = OUT_W'(acc_l_q) << Shift;
                  out_r_d    = OUT_W'(acc_r_q) << Shift;
                  valid_d    = 1'b1;
                  acc_l_d    = c_l;
                  acc_r_d    = c_r;
                  slot_cnt_d = CntStart;
               end else begin
                  acc_l_d    = acc_l_q + c_l;
                  acc_r_d    = acc_r_q + c_r;
                  slot_cnt_d = (slot_cnt_q == CntLast) ? '0 : slot_cnt_q + 1'b1;
               end
            end
            default: state_d = StUnlocked;
         endcase
      end
   end

   always_ff @(posedge MCLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StUnlocked;
         slot_cnt_q   <= '0;
         acc_l_q      <= '0;
         acc_r_q      <= '0;
         out_l        <= '0;
         out_r        <= '0;
         sample_valid <= 1'b0;
         locked       <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_cnt_q   <= slot_cnt_d;
         acc_l_q      <= acc_l_d;
         acc_r_q      <= acc_r_d;
         out_l        <= out_l_d;
         out_r        <= out_r_d;
         sample_valid <= valid_d;
         locked       <= locked_d;
         sync_err     <= err_d;
      end
   end

endmodule

// File: tb/tb_ym3438_dac_rx.sv
// Directed bench for ym3438_dac_rx: an integer period-sum model checked every
// cycle, plus literal expectations at each sample boundary.
module tb_ym3438_dac_rx;

   localparam int SLOTS = 24;
   localparam int OUT_W = 16;
   localparam int SCALE = 4;   // 1 << (OUT_W - 14)

   logic             MCLK = 1'b0;
   logic             reset_n = 1'b0;
   logic             c1 = 1'b0;
   logic             sync = 1'b0;
   logic [8:0]       ch_out = 9'h100;
   logic [1:0]       ch_pan = 2'b00;
   logic             mute = 1'b0;
   logic [OUT_W-1:0] out_l, out_r;
   logic             sample_valid, locked, sync_err;

   int tests = 0;
   int fails = 0;
   int gap = 0;

   // Model: sums kept as plain ints, pos = slots already in the current period.
   int m_lk, m_err, m_pos, m_sl, m_sr, m_ol, m_or, m_v;

   ym3438_dac_rx #(.SLOTS(SLOTS), .OUT_W(OUT_W)) dut (
      .MCLK(MCLK),
      .reset_n(reset_n),
      .c1(c1),
      .sync(sync),
      .ch_out(ch_out),
      .ch_pan(ch_pan),
      .mute(mute),
      .out_l(out_l),
      .out_r(out_r),
      .sample_valid(sample_valid),
      .locked(locked),
      .sync_err(sync_err)
   );

   always #5 MCLK = ~MCLK;

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lk = 0; m_err = 0; m_pos = 0; m_sl = 0; m_sr = 0;
      m_ol = 0; m_or = 0; m_v = 0;
   endtask

   task automatic model_slot(input bit s, input logic [8:0] d, input logic [1:0] p,
                             input bit m);
      int v, cl, cr;
      v  = int'(d) - 256;
      cl = (p[1] && !m) ? v : 0;
      cr = (p[0] && !m) ? v : 0;
      if (m_lk == 0) begin
         if (s) begin
            m_lk = 1; m_sl = cl; m_sr = cr; m_pos = 1;
         end
      end else begin
         if (s != (m_pos == SLOTS)) m_err = 1;
         if (s || m_pos == SLOTS) begin
            m_ol = m_sl * SCALE; m_or = m_sr * SCALE; m_v = 1;
            m_sl = cl; m_sr = cr; m_pos = 1;
         end else begin
            m_sl += cl; m_sr += cr; m_pos++;
         end
      end
   endtask

   // One MCLK cycle; inputs change 2 time units after the rising edge.
   task automatic step(input bit c, input bit s, input logic [8:0] d,
                       input logic [1:0] p, input bit m);
      c1 = c; sync = s; ch_out = d; ch_pan = p; mute = m;
      @(posedge MCLK);
      if (reset_n) begin
         m_v = 0;
         if (c) model_slot(s, d, p, m);
      end
      #2;
   endtask

   // Idle cycles carry junk that must be ignored while c1 is low.
   task automatic slot(input bit s, input logic [8:0] d, input logic [1:0] p, input bit m);
      for (int i = 0; i < gap; i++) step(1'b0, 1'b1, 9'h1FF, 2'b11, 1'b0);
      step(1'b1, s, d, p, m);
   endtask

   task automatic period(input int n, input bit first_sync, input logic [8:0] d,
                         input logic [1:0] p);
      for (int i = 0; i < n; i++) slot((i == 0) ? first_sync : 1'b0, d, p, 1'b0);
   endtask

   task automatic boundary_chk(input string nm, input int el, input int er, input int err);
      chk({nm, "_valid"}, int'(sample_valid), 1);
      chk({nm, "_out_l"}, int'($signed(out_l)), el);
      chk({nm, "_out_r"}, int'($signed(out_r)), er);
      chk({nm, "_sync_err"}, int'(sync_err), err);
   endtask

   always @(negedge MCLK) begin
      chk("out_l", int'($signed(out_l)), m_ol);
      chk("out_r", int'($signed(out_r)), m_or);
      chk("sample_valid", int'(sample_valid), m_v);
      chk("locked", int'(locked), m_lk);
      chk("sync_err", int'(sync_err), m_err);
   end

   initial begin
      model_reset();
      repeat (3) step(1'b0, 1'b0, 9'h100, 2'b00, 1'b0);
      reset_n = 1'b1;
      chk("reset_out_l", int'(out_l), 0);
      chk("reset_locked", int'(locked), 0);
      chk("reset_sync_err", int'(sync_err), 0);

      repeat (5) slot(1'b0, 9'h1FF, 2'b11, 1'b0);
      chk("unlocked_no_lock", int'(locked), 0);

      // +255 on left only for a full period.
      slot(1'b1, 9'h1FF, 2'b10, 1'b0);
      chk("lock_on_sync", int'(locked), 1);
      period(SLOTS - 1, 1'b0, 9'h1FF, 2'b10);
      slot(1'b1, 9'h000, 2'b11, 1'b0);
      boundary_chk("pos_full", 24480, 0, 0);
      period(SLOTS - 1, 1'b0, 9'h000, 2'b11);
      slot(1'b1, 9'h100, 2'b11, 1'b0);
      boundary_chk("neg_full", -24576, -24576, 0);
      period(SLOTS - 1, 1'b0, 9'h100, 2'b11);

      // Alternate L/R slots of +16, first four L slots muted.
      for (int i = 0; i < SLOTS; i++) begin
         slot(i == 0, 9'h110, (i % 2 == 0) ? 2'b10 : 2'b01, (i % 2 == 0) && (i < 8));
         if (i == 0) boundary_chk("zero", 0, 0, 0);
      end
      slot(1'b1, 9'h110, 2'b11, 1'b0);
      boundary_chk("pan_mute", 512, 768, 0);
      period(SLOTS - 1, 1'b0, 9'h110, 2'b11);

      // Withheld sync: period still wraps on the free-running count.
      slot(1'b0, 9'h110, 2'b11, 1'b0);
      boundary_chk("missing", 1536, 1536, 1);
      period(SLOTS - 1, 1'b0, 9'h120, 2'b10);

      gap = 7;
      slot(1'b1, 9'h120, 2'b10, 1'b0);
      boundary_chk("wrapped", 3008, 64, 1);
      period(SLOTS - 1, 1'b0, 9'h120, 2'b10);
      gap = 0;
      slot(1'b1, 9'h100, 2'b00, 1'b0);
      boundary_chk("gapped", 3072, 0, 1);

      // Reset while 12 slots into a period.
      period(11, 1'b0, 9'h120, 2'b11);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("midreset_out_l", int'(out_l), 0);
      chk("midreset_out_r", int'(out_r), 0);
      chk("midreset_locked", int'(locked), 0);
      chk("midreset_sync_err", int'(sync_err), 0);
      repeat (2) step(1'b1, 1'b1, 9'h1FF, 2'b11, 1'b0);
      reset_n = 1'b1;
      repeat (3) slot(1'b0, 9'h1FF, 2'b11, 1'b0);
      chk("post_reset_locked", int'(locked), 0);

      // Early sync after 10 slots, then a normal period counted from it.
      period(10, 1'b1, 9'h110, 2'b11);
      slot(1'b1, 9'h110, 2'b11, 1'b0);
      boundary_chk("early", 640, 640, 1);
      period(SLOTS - 1, 1'b0, 9'h110, 2'b11);
      slot(1'b1, 9'h100, 2'b11, 1'b0);
      boundary_chk("after_early", 1536, 1536, 1);

      repeat (4) step(1'b0, 1'b0, 9'h100, 2'b00, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ym3438_dac_rx.md
Name: ym3438_dac_rx

Overview:
Receiving end of the channel-output interface. Consumes the time-multiplexed 9-bit offset-binary channel stream and the gated pan bits that the channel block emits once per YM slot. Decodes each slot to signed, accumulates left and right over one sample period, and presents a latched stereo PCM sample with a one-cycle valid strobe. Sits between the channel block and the board-level mixer/PWM or I2S output stage.

Parameters:
SLOTS, 24, slots per sample period; one c1 enable per slot.
OUT_W, 16, width of the signed output samples; must be at least 14.

Ports:
MCLK  input  1  master clock; all state updates on posedge.
reset_n  input  1  asynchronous active-low reset.
c1  input  1  slot clock enable; one slot is processed per MCLK edge with c1=1.
sync  input  1  slot-0 marker from the FSM; sampled only when c1=1.
ch_out  input  9  channel value, offset binary (0x100 = zero).
ch_pan  input  2  {L,R} enables; already zero outside the DAC load window.
mute  input  1  forces zero contribution for the current slot.
out_l  output  OUT_W  signed left sample, latched per period.
out_r  output  OUT_W  signed right sample, latched per period.
sample_valid  output  1  one-MCLK pulse when out_l/out_r update.
locked  output  1  high after the first accepted sync.
sync_err  output  1  sticky flag for a missing or early sync.

Behaviour:
- Clock and reset: one clock, MCLK. Reset reset_n is asynchronous and active-low.
- Reset values: out_l=0, out_r=0, sample_valid=0, locked=0, sync_err=0. Internal: slot_cnt=0, acc_l=0, acc_r=0, FSM in UNLOCKED.
- Reset asserted mid-period discards the partial sums. No sample is emitted.
- Decode: val = {~ch_out[8], ch_out[7:0]} as 9-bit two's complement, range -256..+255.
- Slot contribution per side: cL = (ch_pan[1] & ~mute) ? val : 0, and cR = (ch_pan[0] & ~mute) ? val : 0.
- Accumulators are 14-bit signed. Worst case is SLOTS x 256 = 6144, so no overflow or saturation is needed.
- Nothing changes on cycles with c1=0. sample_valid is cleared on every MCLK edge unless it is set on that edge.
- UNLOCKED state:
  - c1 & ~sync: ignore the slot; accumulators stay 0 and slot_cnt stays 0.
  - c1 & sync: go to LOCKED, set locked=1, acc_l<=cL, acc_r<=cR, slot_cnt<=1.
  - No sample is emitted for this first boundary.
- LOCKED state, on each c1: boundary = sync | (slot_cnt==0).
  - If boundary:
    - out_l <= acc_l sign-extended and shifted left by (OUT_W-14). Same for out_r.
    - sample_valid <= 1 (latency: valid in the MCLK cycle after the boundary edge).
    - acc_l <= cL, acc_r <= cR; this slot starts the new period.
    - slot_cnt <= 1 (wraps to 0 when SLOTS=1).
  - Else: acc += c for each side, and slot_cnt <= (slot_cnt==SLOTS-1) ? 0 : slot_cnt+1.
- Sync error conditions:
  - Early sync: sync with slot_cnt!=0. Set sync_err=1 and realign to that sync.
  - Missing sync: slot_cnt==0 with sync=0. Set sync_err=1 and wrap the period by free-running count.
- sync_err is cleared only by reset. locked stays 1 until reset.
- Simultaneous events: sync together with slot_cnt==0 is the normal boundary (no error). Only one boundary is taken per c1.

Test Plan:
- Reset and lock: reset_n low then high; drive 5 c1 slots with sync=0 and ch_pan=11 -> no sample_valid, locked=0. Then sync=1 -> locked=1.
- Decode extremes: lock, then 24 slots of ch_out=9'h1FF with ch_pan=10, then sync -> sample_valid one cycle; out_l=24480 (6120<<2), out_r=0.
- Negative full scale: 24 slots of ch_out=9'h000 with ch_pan=11 -> out_l=out_r=-24576. With ch_out=9'h100 -> both 0.
- Pan and mute gating: slots alternate ch_pan=01/10 with ch_out=9'h110 (+16); mute=1 on 4 of the L slots -> out_l=(12-4)*16*4=512, out_r=12*16*4=768.
- Sync errors:
  - Sync after slot 10 -> sync_err=1; a sample is latched with the 10-slot sum; the next period is counted from that sync.
  - Sync withheld at slot 24 -> sync_err=1; the period still wraps and sample_valid still pulses.
- c1 gaps and reset mid-period: hold c1=0 for 7 MCLK between slots -> identical results to back-to-back slots. Assert reset_n at slot 12 -> all outputs 0 and locked=0 asynchronously; no spurious sample_valid after release.
